// File: rtl/dice_turn_manager.sv
// Turn sequencer for a colour-dice board game: accepts rolls, drives a move handshake, tracks positions.
// Optional WAIT_ROLL timeout is included when DICE_TURN_TIMEOUT_EN is defined.
module dice_turn_manager #(
    parameter int          NUM_PLAYERS  = 2,
    parameter int          TRACK_LEN    = 32,
    parameter logic [15:0] WHITE_HOLD   = 16'd1000,
    parameter logic [31:0] ROLL_TIMEOUT = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  stable_color,
    input  logic        result_ready,
    input  logic        current_state_white,
    output logic        move_valid,
    input  logic        move_ready,
    output logic [1:0]  move_player,
    output logic [1:0]  move_steps,
    output logic [23:0] positions,
    output logic [1:0]  cur_player,
    output logic [2:0]  phase,
    output logic        game_over,
    output logic [1:0]  winner
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_ROLL  = 3'd1,
        S_MOVE       = 3'd2,
        S_WAIT_CLEAR = 3'd3,
        S_ADVANCE    = 3'd4,
        S_GAME_OVER  = 3'd5
    } state_t;

    localparam logic [6:0] GOAL = 7'(TRACK_LEN - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_white_cnt;
    logic        r_after_move;
    logic [1:0]  r_cur_player;
    logic [1:0]  r_move_player;
    logic [1:0]  r_move_steps;
    logic [1:0]  r_winner;
    logic        r_game_over;
    logic        w_start_game;
    logic        w_accept;
    logic        w_move_fire;
    logic        w_white_done;
    logic        w_timeout;
    logic [5:0]  w_cur_pos;
    logic [6:0]  w_sum;
    logic [6:0]  w_new_pos;
    logic [23:0] w_positions;

    assign w_start_game = ((r_state == S_IDLE) || (r_state == S_GAME_OVER)) && start;
    assign w_accept     = (r_state == S_WAIT_ROLL) && result_ready && (stable_color != 2'b00);
    assign w_move_fire  = (r_state == S_MOVE) && move_ready;
    assign w_white_done = (r_state == S_WAIT_CLEAR) && current_state_white
                          && (r_white_cnt == WHITE_HOLD - 16'd1);

    // Colour code doubles as step count: RED=1, GREEN=2, BLUE=3.
    assign w_cur_pos = w_positions[6*r_move_player +: 6];
    assign w_sum     = {1'b0, w_cur_pos} + {5'd0, r_move_steps};
    assign w_new_pos = (w_sum > GOAL) ? GOAL : w_sum;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pos
            if (gi < NUM_PLAYERS) begin : g_active
                logic [5:0] r_pos;
                always_ff @(posedge clk) begin
                    if (!reset || w_start_game) begin
                        r_pos <= '0;
                    end else if (w_move_fire && (r_move_player == 2'(gi))) begin
                        r_pos <= w_new_pos[5:0];
                    end
                end
                assign w_positions[6*gi +: 6] = r_pos;
            end else begin : g_absent
                assign w_positions[6*gi +: 6] = 6'd0;
            end
        end
    endgenerate

`ifdef DICE_TURN_TIMEOUT_EN
    logic [31:0] r_roll_cnt;
    // Held at zero outside WAIT_ROLL, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset || (r_state != S_WAIT_ROLL)) begin
            r_roll_cnt <= '0;
        end else begin
            r_roll_cnt <= r_roll_cnt + 32'd1;
        end
    end
    assign w_timeout = (r_state == S_WAIT_ROLL) && (r_roll_cnt == ROLL_TIMEOUT - 32'd1);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^ROLL_TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        move_valid   = 1'b0;
        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (start) w_state_next = S_WAIT_CLEAR;
            end
            S_WAIT_ROLL: begin
                if (w_accept)       w_state_next = S_MOVE;
                else if (w_timeout) w_state_next = S_ADVANCE;
            end
            S_MOVE: begin
                move_valid = 1'b1;
                if (move_ready) w_state_next = (w_new_pos == GOAL) ? S_GAME_OVER : S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                // The very first turn of a game keeps player 0 without an advance.
                if (w_white_done) w_state_next = r_after_move ? S_ADVANCE : S_WAIT_ROLL;
            end
            S_ADVANCE: w_state_next = S_WAIT_ROLL;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || (r_state != S_WAIT_CLEAR) || !current_state_white) begin
            r_white_cnt <= '0;
        end else begin
            r_white_cnt <= r_white_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_player  <= '0;
            r_move_player <= '0;
            r_move_steps  <= '0;
            r_after_move  <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= '0;
        end else begin
            if (w_start_game) begin
                r_cur_player <= '0;
                r_after_move <= 1'b0;
                r_game_over  <= 1'b0;
                r_winner     <= '0;
            end
            if (w_accept) begin
                r_move_player <= r_cur_player;
                r_move_steps  <= stable_color;
            end
            if (w_move_fire) begin
                r_after_move <= 1'b1;
                if (w_new_pos == GOAL) begin
                    r_game_over <= 1'b1;
                    r_winner    <= r_move_player;
                end
            end
            if (r_state == S_ADVANCE) begin
                r_cur_player <= (r_cur_player == 2'(NUM_PLAYERS - 1)) ? 2'd0 : r_cur_player + 2'd1;
            end
        end
    end

    assign move_player = r_move_player;
    assign move_steps  = r_move_steps;
    assign positions   = w_positions;
    assign cur_player  = r_cur_player;
    assign phase       = r_state;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
endmodule

// File: tb/tb_dice_turn_manager.sv
// Scoreboard bench for dice_turn_manager: random games against a rule-level model of the board.
// Timeout expectations follow DICE_TURN_TIMEOUT_EN when the macro is defined for the build.
module tb_dice_turn_manager;
    localparam int          NP = 2;
    localparam int          TL = 32;
    localparam int          H  = 8;
    localparam logic [15:0] WH = 16'd8;
    localparam logic [31:0] RT = 32'd20;

    logic        clk = 1'b0;
    logic        reset, start, result_ready, current_state_white, move_ready;
    logic [1:0]  stable_color;
    logic        move_valid, game_over;
    logic [1:0]  move_player, move_steps, cur_player, winner;
    logic [23:0] positions;
    logic [2:0]  phase;

    dice_turn_manager #(
        .NUM_PLAYERS(NP), .TRACK_LEN(TL), .WHITE_HOLD(WH), .ROLL_TIMEOUT(RT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stable_color(stable_color),
        .result_ready(result_ready), .current_state_white(current_state_white),
        .move_valid(move_valid), .move_ready(move_ready), .move_player(move_player),
        .move_steps(move_steps), .positions(positions), .cur_player(cur_player),
        .phase(phase), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  player;
        logic [1:0]  steps;
        logic [23:0] pos;
        logic [2:0]  phase_after;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_e;
    bit   pend = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mpos[4];
    int   mcur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [23:0] pack_pos();
        return {6'(mpos[3]), 6'(mpos[2]), 6'(mpos[1]), 6'(mpos[0])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget);
        int n = 0;
        while (phase !== p && n < budget) begin
            tick();
            n++;
        end
        chk("wait_phase", 32'(phase), 32'(p));
    endtask

    // Monitor: checks every presented move against the scoreboard, then the board after it.
    always @(negedge clk) begin
        if (pend) begin
            pend = 0;
            chk("pos_after_move", 32'(positions), 32'(pend_e.pos));
            chk("phase_after_move", 32'(phase), 32'(pend_e.phase_after));
            if (pend_e.phase_after == 3'd5) begin
                chk("win_game_over", 32'(game_over), 32'd1);
                chk("win_winner", 32'(winner), 32'(pend_e.player));
            end
        end
        if (reset && move_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_move: move_valid=1 required=0 (nothing pending)");
            end else begin
                chk("move_player", 32'(move_player), 32'(exp_q[0].player));
                chk("move_steps", 32'(move_steps), 32'(exp_q[0].steps));
                if (move_ready) begin
                    $display("move player=%0d steps=%0d", move_player, move_steps);
                    pend_e = exp_q.pop_front();
                    pend = 1;
                end
            end
        end
    end

    task automatic white_run(input bit adv);
        current_state_white = 1'b1;
        repeat (H) tick();
        current_state_white = 1'b0;
        if (adv) mcur = (mcur + 1) % NP;
        wait_phase(3'd1, 4);
        chk("turn_owner", 32'(cur_player), 32'(mcur));
    endtask

    // White drops two short of the hold, with a stray roll in WAIT_CLEAR, then a full run.
    task automatic glitch_run();
        current_state_white = 1'b1;
        repeat (H - 2) tick();
        current_state_white = 1'b0;
        stable_color = 2'd2;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("clear_roll_ignored", 32'(phase), 32'd3);
        current_state_white = 1'b1;
        repeat (H - 1) tick();
        chk("glitch_no_advance", 32'(phase), 32'd3);
        tick();
        chk("advance_phase", 32'(phase), 32'd4);
        chk("advance_old_player", 32'(cur_player), 32'(mcur));
        current_state_white = 1'b0;
        tick();
        mcur = (mcur + 1) % NP;
        chk("advance_done", 32'(phase), 32'd1);
        chk("advance_new_player", 32'(cur_player), 32'(mcur));
    endtask

    task automatic do_turn(input int color, input int stall, output bit won);
        exp_t e;
        int np;
        chk("turn_player", 32'(cur_player), 32'(mcur));
        if ($urandom_range(0, 1) == 1) begin
            stable_color = 2'd0;
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            chk("none_ignored", 32'(phase), 32'd1);
        end
        np = mpos[mcur] + color;
        if (np > TL - 1) np = TL - 1;
        mpos[mcur] = np;
        won = (np == TL - 1);
        e.player = 2'(mcur);
        e.steps = 2'(color);
        e.pos = pack_pos();
        e.phase_after = won ? 3'd5 : 3'd3;
        exp_q.push_back(e);
        stable_color = 2'(color);
        result_ready = 1'b1;
        current_state_white = 1'($urandom_range(0, 1));
        tick();
        result_ready = 1'b0;
        current_state_white = 1'b0;
        stable_color = 2'($urandom_range(0, 3));
        chk("valid_latency", 32'(move_valid), 32'd1);
        chk("move_phase", 32'(phase), 32'd2);
        repeat (stall) tick();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        tick();
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) mpos[i] = 0;
        mcur = 0;
        chk("start_phase", 32'(phase), 32'd3);
        chk("start_positions", 32'(positions), 32'd0);
        chk("start_game_over", 32'(game_over), 32'd0);
        white_run(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit won;
        bit first;
        int turns;
        int color;
        exp_t e;
        reset = 1'b0; start = 1'b0; result_ready = 1'b0; current_state_white = 1'b0;
        move_ready = 1'b0; stable_color = 2'd0;
        tick(); tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_move_valid", 32'(move_valid), 32'd0);
        chk("rst_positions", 32'(positions), 32'd0);
        chk("rst_cur_player", 32'(cur_player), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_move_payload", 32'({move_player, move_steps}), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", 32'(phase), 32'd0);

        for (int g = 0; g < 2; g++) begin
            start_game();
            won = 0;
            turns = 0;
            first = (g == 0);
            while (!won && turns < 200) begin
                if (first) begin
                    do_turn(2, 5, won);
                end else begin
                    color = (mpos[mcur] == TL - 2) ? 3 : int'($urandom_range(1, 3));
                    do_turn(color, int'($urandom_range(0, 3)), won);
                end
                turns++;
                if (!won) begin
                    if (first) glitch_run();
                    else white_run(1'b1);
                    first = 0;
                end
            end
            chk("game_finished", 32'(game_over), 32'd1);
            stable_color = 2'd3;
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            tick();
            chk("over_phase", 32'(phase), 32'd5);
            chk("over_positions", 32'(positions), 32'(pack_pos()));
            chk("over_winner", 32'(winner), 32'(mcur));
            chk("over_no_valid", 32'(move_valid), 32'd0);
        end

        start_game();
        repeat (19) tick();
        chk("roll_wait_19", 32'(phase), 32'd1);
        tick();
`ifdef DICE_TURN_TIMEOUT_EN
        chk("timeout_advance", 32'(phase), 32'd4);
        tick();
        mcur = (mcur + 1) % NP;
        chk("timeout_back_to_roll", 32'(phase), 32'd1);
        chk("timeout_player", 32'(cur_player), 32'(mcur));
`else
        chk("no_timeout", 32'(phase), 32'd1);
`endif
        chk("timeout_positions", 32'(positions), 32'(pack_pos()));

        e.player = 2'(mcur);
        e.steps = 2'd1;
        e.pos = pack_pos();
        e.phase_after = 3'd3;
        exp_q.push_back(e);
        stable_color = 2'd1;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("rst_case_valid", 32'(move_valid), 32'd1);
        tick();
        reset = 1'b0;
        move_ready = 1'b1;
        tick();
        chk("midrst_valid", 32'(move_valid), 32'd0);
        chk("midrst_phase", 32'(phase), 32'd0);
        chk("midrst_positions", 32'(positions), 32'd0);
        exp_q.delete();
        reset = 1'b1;
        move_ready = 1'b0;
        tick(); tick();
        chk("post_reset_idle", 32'(phase), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dice_turn_manager.md
DICE_TURN_MANAGER -- requirements
Module: dice_turn_manager

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of active players; legal range 2..4.
REQ-002 Parameter TRACK_LEN, default 32, number of board squares; legal range 2..63; the goal square is TRACK_LEN-1.
REQ-003 Parameter WHITE_HOLD, default 16'd1000, consecutive cycles of white background required to close a turn.
REQ-004 Parameter ROLL_TIMEOUT, default 32'd100_000_000, WAIT_ROLL cycle limit; used only when DICE_TURN_TIMEOUT_EN is defined.
REQ-005 Port clk, input, 1, single clock; all logic runs on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-low reset.
REQ-007 Port start, input, 1, pulse that begins a new game.
REQ-008 Port stable_color, input, 2, detected dice colour: 00=NONE, 01=RED, 10=GREEN, 11=BLUE.
REQ-009 Port result_ready, input, 1, one-cycle pulse marking stable_color valid.
REQ-010 Port current_state_white, input, 1, level that is high while a white background is detected.
REQ-011 Port move_valid, output, 1, move handshake valid.
REQ-012 Port move_ready, input, 1, move handshake ready from the board/display logic.
REQ-013 Port move_player, output, 2, index of the moving player.
REQ-014 Port move_steps, output, 2, steps to move: RED=1, GREEN=2, BLUE=3.
REQ-015 Port positions, output, 24, four 6-bit player positions; player p occupies [6p+5:6p].
REQ-016 Port cur_player, output, 2, index of the player whose turn it is.
REQ-017 Port phase, output, 3, current FSM state encoding (see REQ-020).
REQ-018 Port game_over, output, 1, level high once a winner exists.
REQ-019 Port winner, output, 2, index of the winning player; valid only while game_over is high.

Function
REQ-020 The FSM shall have these states and encodings: IDLE=0, WAIT_ROLL=1, MOVE=2, WAIT_CLEAR=3, ADVANCE=4, GAME_OVER=5.
REQ-021 IDLE: when start=1, the block shall clear all positions, set cur_player to 0, and enter WAIT_CLEAR, so the first turn also requires a white background first.
REQ-022 WAIT_ROLL: on result_ready=1 with stable_color!=00, the block shall latch steps and cur_player and enter MOVE; move_valid shall rise on the next cycle (1-cycle latency).
REQ-023 result_ready with stable_color=00, and result_ready in any state other than WAIT_ROLL, shall be ignored.
REQ-024 If result_ready and current_state_white are both high in WAIT_ROLL, the result shall be accepted.
REQ-025 MOVE: move_valid shall stay high and move_player/move_steps shall stay stable until move_ready=1.
REQ-026 On the move_valid&&move_ready cycle, the position shall update to min(pos+steps, TRACK_LEN-1).
- If the new position equals TRACK_LEN-1: set game_over, set winner=cur_player, enter GAME_OVER.
- Otherwise: enter WAIT_CLEAR.
REQ-027 move_valid shall be high only in the MOVE state.
REQ-028 WAIT_CLEAR: a 16-bit counter shall increment while current_state_white=1 and clear to 0 whenever it is 0.
REQ-029 When the WAIT_CLEAR counter reaches WHITE_HOLD-1 with white still high, the block shall enter ADVANCE.
- After a move: the next player takes the turn.
- After a start: player 0 keeps the turn, with no advance.
REQ-030 ADVANCE shall last exactly one cycle: cur_player = (cur_player==NUM_PLAYERS-1) ? 0 : cur_player+1, then enter WAIT_ROLL.
REQ-031 GAME_OVER shall hold every output until start=1, which behaves exactly as REQ-021 and clears game_over.
REQ-032 start shall be ignored in WAIT_ROLL, MOVE, WAIT_CLEAR and ADVANCE.
REQ-033 Positions of players with index ≥ NUM_PLAYERS shall remain 0.

Reset
REQ-034 While reset=0 at a clk edge, the block shall enter IDLE and clear all counters.
REQ-035 Reset shall drive these outputs to: move_valid=0, move_player=0, move_steps=0, positions=0, cur_player=0, phase=0, game_over=0, winner=0.
REQ-036 Reset asserted mid-handshake shall drop move_valid on the next edge, with no position update.

Configuration
REQ-037 When macro DICE_TURN_TIMEOUT_EN is defined, a 32-bit WAIT_ROLL counter shall be included.
- It counts cycles spent in WAIT_ROLL.
- On reaching ROLL_TIMEOUT-1 with no accepted result, the block shall enter ADVANCE, skipping the turn with no move.
- The counter clears on every entry to WAIT_ROLL.
REQ-038 When DICE_TURN_TIMEOUT_EN is not defined, no timeout logic shall exist and WAIT_ROLL shall wait indefinitely.

Verification
REQ-039 Reset, start, white held for WHITE_HOLD cycles -> phase=1 and cur_player=0; then result_ready with color 10 -> next cycle move_valid=1, move_steps=2, move_player=0.
REQ-040 In MOVE, hold move_ready=0 for 5 cycles, then assert it -> move_valid stays high with a stable payload; then positions[5:0]=2 and phase=3.
REQ-041 White dropped at count WHITE_HOLD-2, then reapplied -> no ADVANCE until a full WHITE_HOLD consecutive run completes; then cur_player goes 0->1, and wraps to 0 with NUM_PLAYERS=2.
REQ-042 Player at position 30 with TRACK_LEN=32 rolls BLUE -> position saturates at 31; game_over=1, winner=player, phase=5; a later result_ready changes nothing; start restarts the game.
REQ-043 result_ready with color 00 in WAIT_ROLL, and result_ready in WAIT_CLEAR -> both ignored; phase is unchanged.
REQ-044 With DICE_TURN_TIMEOUT_EN defined and ROLL_TIMEOUT=20 -> idle in WAIT_ROLL for 20 cycles gives ADVANCE with no position change; without the macro, phase stays at 1.
